// File: rtl/gate_selftest_seq_if.sv
// Handshake and result bundle between the gate self-test sequencer and its host/datapath.
// The master side is the sequencer; the slave side is the host plus the gate datapath.
interface gate_selftest_seq_if;
   logic       start;
   logic       abort;
   logic       dut_a;
   logic       dut_b;
   logic [6:0] dut_res;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       pass;
   logic [6:0] fail_mask;
   logic [1:0] first_fail_vec;

   modport master (
      input  start, abort, dut_res,
      output dut_a, dut_b, busy, done, aborted, pass, fail_mask, first_fail_vec
   );

   modport slave (
      output start, abort, dut_res,
      input  dut_a, dut_b, busy, done, aborted, pass, fail_mask, first_fail_vec
   );
endinterface

// File: rtl/gate_selftest_seq.sv
// Exhaustive 2-input self-test of a 7-gate datapath: walks {a,b} through 00..11,
// holds each vector SETTLE_CYCLES cycles, then compares the results against the ideal gates.
//
// state   | meaning
// S_IDLE  | waiting for start; operands driven 0
// S_APPLY | driving vector idx_q, settling for SETTLE_CYCLES cycles
// S_CHECK | one-cycle compare of dut_res against expected gates
// S_DONE  | one-cycle done pulse with final pass verdict
module gate_selftest_seq #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input logic                  clk,
   input logic                  rst,
   gate_selftest_seq_if.master  bus
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] mask_q, mask_d;
   logic [1:0] ffv_q, ffv_d;
   logic       pass_q, pass_d;
   logic       aborted_q, aborted_d;

   logic       op_a, op_b;
   logic [6:0] exp_res;
   logic [6:0] mism;

   assign op_a = idx_q[1];
   assign op_b = idx_q[0];
   assign exp_res = {~(op_a ^ op_b), op_a ^ op_b, ~(op_a | op_b), ~(op_a & op_b),
                     ~op_a, op_a | op_b, op_a & op_b};
   assign mism = bus.dut_res ^ exp_res;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= 2'd0;
         cnt_q     <= 4'd0;
         mask_q    <= 7'd0;
         ffv_q     <= 2'd0;
         pass_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         ffv_q     <= ffv_d;
         pass_q    <= pass_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      ffv_d     = ffv_q;
      pass_d    = pass_q;
      aborted_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_APPLY;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
               mask_d  = 7'd0;
               ffv_d   = 2'd0;
               pass_d  = 1'b0;
            end
         end
         S_APPLY: begin
            if (bus.abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
               pass_d    = 1'b0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            // abort discards this compare so the recorded failures reflect completed checks only
            if (bus.abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               mask_d = mask_q | mism;
               if ((mism != 7'd0) && (mask_q == 7'd0)) ffv_d = idx_q;
               if (idx_q == 2'd3) begin
                  state_d = S_DONE;
                  pass_d  = ((mask_q | mism) == 7'd0);
               end else begin
                  state_d = S_APPLY;
                  idx_d   = idx_q + 2'd1;
                  cnt_d   = 4'd0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (bus.abort) begin
               aborted_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic drive_vec;
   assign drive_vec = (state_q == S_APPLY) || (state_q == S_CHECK);

   assign bus.dut_a          = drive_vec & op_a;
   assign bus.dut_b          = drive_vec & op_b;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = (state_q == S_DONE);
   assign bus.aborted        = aborted_q;
   assign bus.pass           = pass_q;
   assign bus.fail_mask      = mask_q;
   assign bus.first_fail_vec = ffv_q;

endmodule
